clock_period_monitor: RTL and testbench
=======================================

CLOCK_PERIOD_MONITOR -- requirements
Module: clock_period_monitor

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: number of synchronizer flops on mon_in (minimum 2).
REQ-002 SHALL have parameter CNT_W, default 16: width of the period counter and bounds.
REQ-003 SHALL have parameter LOCK_COUNT, default 4: consecutive in-range periods required to assert locked.
REQ-004 SHALL have port clock, input, 1: the single reference clock; all state is clocked on its rising edge.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port enable, input, 1: monitor run control.
REQ-007 SHALL have port mon_in, input, 1: monitored clock, for example a skewed or delayed clock output, asynchronous to clock.
REQ-008 SHALL have ports min_period and max_period, input, CNT_W each: inclusive legal period bounds, in clock cycles.
REQ-009 SHALL have ports meas_valid (output, 1), meas_ready (input, 1) and meas_period (output, CNT_W): the measurement handshake.
REQ-010 SHALL have port locked, output, 1: LOCK_COUNT consecutive in-range periods have been seen.
REQ-011 SHALL have ports err_short, err_long and overrun, output, 1 each: sticky error flags.
REQ-012 SHALL have port err_count, output, 8: saturating count of bad periods.
REQ-013 SHALL have port clear_err, input, 1: synchronous clear of the sticky flags and err_count.

Function
REQ-014 SHALL pass mon_in through SYNC_STAGES flops; rise SHALL be high when the synchronized value is 1 and the previous synchronized value was 0.
REQ-015 SHALL implement the FSM IDLE -> ARM (enable=1) -> MEASURE (first rise in ARM); enable=0 in any state SHALL return to IDLE on the next cycle.
REQ-016 In IDLE, the FSM SHALL clear the counter, the good-period count, locked and the timeout flag; sticky errors SHALL be held.
REQ-017 In ARM, on rise, the FSM SHALL load counter=1 and SHALL produce no measurement.
REQ-018 In MEASURE with no rise, the counter SHALL increment by 1 per cycle, saturating at 2^CNT_W-1.
REQ-019 In MEASURE on rise:
- period = current counter value;
- counter reloads to 1.
Rises at cycles t and t+P SHALL therefore yield period=P.
REQ-020 A period SHALL be in-range when min_period <= period <= max_period, compared unsigned. An in-range period SHALL increment the good count, saturating at LOCK_COUNT; locked SHALL be 1 while good count == LOCK_COUNT.
REQ-021 A period < min_period SHALL:
- set err_short;
- clear the good count and locked;
- increment err_count.
REQ-022 Timeout: in MEASURE, the first cycle in which counter > max_period without a rise SHALL:
- set err_long and the timeout flag;
- clear the good count and locked;
- increment err_count once.
REQ-023 The rise that closes a timed-out period SHALL be reported on meas_period. It SHALL NOT increment err_count again and SHALL NOT count as good. The timeout flag SHALL then clear.
REQ-024 Each MEASURE rise SHALL register meas_valid=1 with meas_period on the following cycle. Latency from the synchronizer output rising to meas_valid SHALL be 1 cycle.
REQ-025 meas_valid and meas_period SHALL hold until a cycle with meas_valid & meas_ready. meas_valid SHALL then drop, unless a new measurement arrives in that same cycle, in which case it loads the new value and stays high.
REQ-026 A new measurement while meas_valid=1 and meas_ready=0 SHALL be discarded and SHALL set overrun. Lock and error evaluation of the discarded period SHALL still occur.
REQ-027 err_count SHALL saturate at 255.
REQ-028 clear_err SHALL zero err_short, err_long, overrun and err_count. An error event in the same cycle SHALL win, leaving the flag set and err_count=1.
REQ-029 Leaving enable high with mon_in static SHALL produce repeated timeout only once per period, since the timeout flag blocks re-counting.

Reset
REQ-030 reset=1 SHALL asynchronously force all of the following; the synchronizer flops SHALL be 0:
- state IDLE;
- counter 0;
- meas_valid=0, meas_period=0;
- locked=0;
- err_short=err_long=overrun=0, err_count=0.
REQ-031 Reset deassertion mid-measurement SHALL resume from IDLE. The first measurement SHALL require two post-reset rises.

Verification
REQ-032 mon_in period 10 cycles, bounds 8..12, meas_ready=1 -> meas_period=10 each edge; locked=1 after the 5th rise (4 periods); no errors.
REQ-033 Locked stream, then one period of 5 -> err_short=1, locked=0, err_count=1; locked returns after 4 further in-range periods.
REQ-034 mon_in held low 30 cycles, max_period=12 -> err_long set at counter=13, err_count=1 only; the next rise reports meas_period=30.
REQ-035 meas_ready=0 across two measurements -> first value held, overrun=1; raising meas_ready with a simultaneous new edge -> meas_valid stays 1 with the new period.
REQ-036 Cases around clear_err, enable and reset:
- clear_err coincident with a short period -> err_short=1, err_count=1;
- enable dropped mid-period -> IDLE, locked=0, errors kept;
- reset asserted asynchronously between clock edges -> all outputs 0 immediately.

Source files
------------

// File: rtl/clock_period_monitor.sv
// Measures the period of an asynchronous monitored clock in reference-clock cycles,
// checks it against programmable bounds, tracks lock and keeps sticky error flags.
module clock_period_monitor #(
  parameter int SYNC_STAGES = 2,  // at least 2
  parameter int CNT_W       = 16,
  parameter int LOCK_COUNT  = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             mon_in,
  input  logic [CNT_W-1:0] min_period,
  input  logic [CNT_W-1:0] max_period,
  output logic             meas_valid,
  input  logic             meas_ready,
  output logic [CNT_W-1:0] meas_period,
  output logic             locked,
  output logic             err_short,
  output logic             err_long,
  output logic             overrun,
  output logic [7:0]       err_count,
  input  logic             clear_err
);

  localparam int               GW       = $clog2(LOCK_COUNT + 1);
  localparam logic [GW-1:0]    GOOD_MAX = GW'(LOCK_COUNT);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {IDLE, ARM, MEASURE} state_t;

  state_t                 state, state_nx;
  logic [SYNC_STAGES-1:0] sync;
  logic                   sync_prev;
  logic                   rise;
  logic [CNT_W-1:0]       counter;
  logic [GW-1:0]          good_cnt;
  logic                   timeout;

  logic meas_evt, meas_load, overrun_evt;
  logic good_evt, short_evt, long_evt, timeout_evt, err_evt;

  assign rise   = sync[SYNC_STAGES-1] & ~sync_prev;
  assign locked = (good_cnt == GOOD_MAX);

  // NOTE: sequential state is written with non-blocking assignments only, so every
  // flop samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    // NOTE: default first so every path assigns state_nx and no latch is inferred.
    state_nx = state;
    if (!enable) state_nx = IDLE;
    else begin
      case (state)
        IDLE:    state_nx = ARM;
        ARM:     if (rise) state_nx = MEASURE;
        MEASURE: state_nx = MEASURE;
        default: state_nx = IDLE;
      endcase
    end
  end

  // Event decode; a period already flagged by timeout is reported but not re-judged.
  always_comb begin
    meas_evt    = 1'b0;
    good_evt    = 1'b0;
    short_evt   = 1'b0;
    long_evt    = 1'b0;
    timeout_evt = 1'b0;
    if (state == MEASURE) begin
      if (rise) begin
        meas_evt = 1'b1;
        if (!timeout) begin
          if (counter < min_period)      short_evt = 1'b1;
          else if (counter > max_period) long_evt  = 1'b1;
          else                           good_evt  = 1'b1;
        end
      end else if (!timeout && (counter > max_period)) begin
        long_evt    = 1'b1;
        timeout_evt = 1'b1;
      end
    end
    err_evt     = short_evt | long_evt;
    meas_load   = meas_evt & (~meas_valid | meas_ready);
    overrun_evt = meas_evt & meas_valid & ~meas_ready;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync        <= '0;
      sync_prev   <= 1'b0;
      counter     <= '0;
      good_cnt    <= '0;
      timeout     <= 1'b0;
      meas_valid  <= 1'b0;
      meas_period <= '0;
      err_short   <= 1'b0;
      err_long    <= 1'b0;
      overrun     <= 1'b0;
      err_count   <= 8'd0;
    end else begin
      sync      <= {sync[SYNC_STAGES-2:0], mon_in};
      sync_prev <= sync[SYNC_STAGES-1];

      if (state == IDLE) begin
        counter  <= '0;
        good_cnt <= '0;
        timeout  <= 1'b0;
      end else begin
        if (rise)                                      counter <= CNT_W'(1);
        else if (state == MEASURE && counter != CNT_MAX) counter <= counter + 1'b1;

        if (err_evt)                              good_cnt <= '0;
        else if (good_evt && good_cnt != GOOD_MAX) good_cnt <= good_cnt + 1'b1;

        if (timeout_evt)   timeout <= 1'b1;
        else if (meas_evt) timeout <= 1'b0;
      end

      if (meas_load) begin
        meas_valid  <= 1'b1;
        meas_period <= counter;
      end else if (meas_valid && meas_ready) begin
        meas_valid <= 1'b0;
      end

      // An error event in the clear cycle survives the clear.
      err_short <= (err_short & ~clear_err) | short_evt;
      err_long  <= (err_long  & ~clear_err) | long_evt;
      overrun   <= (overrun   & ~clear_err) | overrun_evt;
      if (clear_err)                           err_count <= err_evt ? 8'd1 : 8'd0;
      else if (err_evt && err_count != 8'hFF)  err_count <= err_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_clock_period_monitor.sv
// Scoreboard bench for clock_period_monitor: stimulus queues expected periods,
// a negedge monitor pops and compares on every accepted measurement.
module tb_clock_period_monitor;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        mon_in = 1'b0;
  logic [15:0] min_period = 16'd8;
  logic [15:0] max_period = 16'd12;
  logic        meas_valid;
  logic        meas_ready = 1'b1;
  logic [15:0] meas_period;
  logic        locked;
  logic        err_short, err_long, overrun;
  logic [7:0]  err_count;
  logic        clear_err = 1'b0;

  int checks   = 0;
  int failures = 0;
  int exp_q[$];

  clock_period_monitor #(.SYNC_STAGES(2), .CNT_W(16), .LOCK_COUNT(4)) dut (
    .clock(clock), .reset(reset), .enable(enable), .mon_in(mon_in),
    .min_period(min_period), .max_period(max_period),
    .meas_valid(meas_valid), .meas_ready(meas_ready), .meas_period(meas_period),
    .locked(locked), .err_short(err_short), .err_long(err_long),
    .overrun(overrun), .err_count(err_count), .clear_err(clear_err)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Drive a rising edge on mon_in (high for 2 cycles); exp >= 0 queues the period it closes.
  task automatic rise_start(input int exp);
    if (exp >= 0) exp_q.push_back(exp);
    mon_in = 1'b1;
    step(2);
    mon_in = 1'b0;
  endtask

  // Rising edge, then wait so the next rise lands exactly gap cycles later.
  task automatic do_rise(input int exp, input int gap);
    rise_start(exp);
    step(gap - 2);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"},   meas_valid,  0);
    check({tag, "_period"},  meas_period, 0);
    check({tag, "_locked"},  locked,      0);
    check({tag, "_short"},   err_short,   0);
    check({tag, "_long"},    err_long,    0);
    check({tag, "_overrun"}, overrun,     0);
    check({tag, "_errcnt"},  err_count,   0);
  endtask

  initial begin : monitor
    int e;
    forever begin
      @(negedge clock);
      if (meas_valid && meas_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_meas: got period %0d expected no measurement", meas_period);
        end else begin
          e = exp_q.pop_front();
          check("meas_period", meas_period, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish within 200000 time units");
    $fatal(1, "watchdog expired");
  end

  initial begin
    enable = 1'b1;
    step(3);
    check_all_zero("reset");
    reset = 1'b0;
    step(2);

    // Stream of period 10 within 8..12: lock after the fifth rise.
    do_rise(-1, 10);
    do_rise(10, 10);
    do_rise(10, 10);
    do_rise(10, 10);
    check("lock_after_3_periods", locked, 0);
    do_rise(10, 10);
    check("lock_after_4_periods", locked, 1);
    check("clean_errcnt", err_count, 0);
    check("clean_short", err_short, 0);
    check("clean_long", err_long, 0);
    check("clean_overrun", overrun, 0);

    // One short period of 5 breaks lock; four good periods restore it.
    do_rise(10, 5);
    do_rise(5, 10);
    check("short_flag", err_short, 1);
    check("short_unlock", locked, 0);
    check("short_errcnt", err_count, 1);
    do_rise(10, 10);
    do_rise(10, 10);
    do_rise(10, 10);
    check("relock_3", locked, 0);
    rise_start(10);
    step(3);
    clear_err = 1'b1;
    step(1);
    clear_err = 1'b0;
    step(4);
    check("relock_4", locked, 1);
    check("clear_errcnt", err_count, 0);
    check("clear_short", err_short, 0);

    // mon_in low for 30 cycles: timeout exactly when the counter reaches 13.
    rise_start(10);
    step(13);
    check("timeout_at_12", err_long, 0);
    step(1);
    check("timeout_at_13", err_long, 1);
    check("timeout_errcnt", err_count, 1);
    check("timeout_unlock", locked, 0);
    step(14);
    check("timeout_once", err_count, 1);
    do_rise(30, 10);
    check("timeout_close_errcnt", err_count, 1);

    // Back-pressure: second measurement discarded, then accept plus new load together.
    meas_ready = 1'b0;
    do_rise(10, 11);
    do_rise(-1, 9);
    check("overrun_flag", overrun, 1);
    check("overrun_hold_valid", meas_valid, 1);
    check("overrun_hold_period", meas_period, 10);
    rise_start(9);
    meas_ready = 1'b1;
    step(1);
    check("reload_valid", meas_valid, 1);
    check("reload_period", meas_period, 9);
    step(1);

    // clear_err in the same cycle as a short period: the new error wins.
    rise_start(4);
    clear_err = 1'b1;
    step(1);
    clear_err = 1'b0;
    check("clr_short_flag", err_short, 1);
    check("clr_short_errcnt", err_count, 1);
    check("clr_long", err_long, 0);
    check("clr_overrun", overrun, 0);
    step(7);

    // Regain lock, then drop enable mid-period.
    do_rise(10, 10);
    do_rise(10, 10);
    do_rise(10, 10);
    do_rise(10, 5);
    check("pre_disable_lock", locked, 1);
    enable = 1'b0;
    step(3);
    check("disable_unlock", locked, 0);
    check("disable_keep_short", err_short, 1);
    check("disable_keep_errcnt", err_count, 1);

    // Re-arm, lock again, then assert reset between clock edges.
    enable = 1'b1;
    step(2);
    do_rise(-1, 10);
    do_rise(10, 10);
    do_rise(10, 10);
    do_rise(10, 10);
    rise_start(10);
    step(4);
    check("pre_reset_lock", locked, 1);
    #2;
    reset = 1'b1;
    #1;
    check_all_zero("async_reset");
    step(2);
    reset = 1'b0;
    step(2);
    do_rise(-1, 10);
    check("post_reset_first_rise", meas_valid, 0);
    do_rise(10, 10);
    step(5);
    check("queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
